program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/program_loader.sv | 111 +++++++++++
 2 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the serial program loader: loader states, the default
// frame header and the instruction opcode type.
package program_loader_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         CODE_DEFAULT   = 4;

  typedef logic [CODE_DEFAULT-1:0] opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/program_loader.sv
// Receives a framed byte stream (header, length, word pairs, XOR checksum),
// writes each word into program memory and releases the core only on a good frame.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR   = 8,
  parameter int         CODE   = 4,
  parameter int         WORD   = ADDR + CODE,
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ready,
  output logic            program_write,
  output logic [ADDR-1:0] program_addr,
  output logic [WORD-1:0] program_cmd,
  output logic            core_rst,
  output logic            done,
  output logic            error
);

  state_e          state_q, state_d;
  logic [7:0]      len_q;
  logic [ADDR-1:0] idx_q;
  logic [7:0]      chk_q;
  logic [CODE-1:0] hi_q;

  logic            rx_ready_q;
  logic            program_write_q;
  logic [ADDR-1:0] program_addr_q;
  logic [WORD-1:0] program_cmd_q;
  logic            core_rst_q;
  logic            done_q;
  logic            error_q;

  logic fire;
  logic hi_illegal;
  logic last_word;

  assign fire       = rx_valid & rx_ready_q;
  assign hi_illegal = (rx_data >> CODE) != 8'd0;
  assign last_word  = (idx_q == ADDR'(len_q - 8'd1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (fire && rx_data == HEADER) state_d = LEN;
      LEN:   if (fire) state_d = (rx_data == 8'd0) ? ERR : HI;
      HI:    if (fire) state_d = hi_illegal ? ERR : LO;
      LO:    if (fire) state_d = WRITE;
      WRITE: state_d = last_word ? CHK : HI;
      CHK:   if (fire) state_d = (rx_data == chk_q) ? DONE : ERR;
      DONE,
      ERR:   if (fire && rx_data == HEADER) state_d = LEN;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      len_q           <= '0;
      idx_q           <= '0;
      chk_q           <= '0;
      hi_q            <= '0;
      rx_ready_q      <= 1'b0;
      program_write_q <= 1'b0;
      program_addr_q  <= '0;
      program_cmd_q   <= '0;
      core_rst_q      <= 1'b1;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      rx_ready_q      <= (state_d != WRITE);
      program_write_q <= (state_d == WRITE);
      core_rst_q      <= (state_d != DONE);
      done_q          <= (state_d == DONE);
      error_q         <= (state_d == ERR);

      if (state_d == LEN) begin
        idx_q <= '0;
        chk_q <= '0;
      end
      if (state_q == LEN && state_d == HI) len_q <= rx_data;
      if (state_q == HI && state_d == LO) begin
        hi_q  <= rx_data[CODE-1:0];
        chk_q <= chk_q ^ rx_data;
      end
      // The lo byte goes straight into the command register; no separate latch.
      if (state_q == LO && state_d == WRITE) begin
        chk_q          <= chk_q ^ rx_data;
        program_cmd_q  <= {hi_q, rx_data};
        program_addr_q <= idx_q;
      end
      if (state_q == WRITE) idx_q <= idx_q + 1'b1;
    end
  end

  assign rx_ready      = rx_ready_q;
  assign program_write = program_write_q;
  assign program_addr  = program_addr_q;
  assign program_cmd   = program_cmd_q;
  assign core_rst      = core_rst_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule
